vga_timing_gen: RTL and testbench

//  Parametrised video timing generator, successor to the fixed 640x480 controller.

---
 rtl/vga_timing_gen.sv | 146 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-rate divider, H/V scan counters,
// sync/active/coordinate decode and line/frame strobes.
// Optional feature macro: VGA_FRAME_CNT_EN adds the 16-bit o_frame_cnt output.
// Line/frame order is FP, SYNC, BP, ACTIVE. Every output is registered from the
// next-state counter values, so outputs always describe the current h/v count.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 4,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned COORD_W  = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_pix_tick,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_active,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_line_start,
`ifdef VGA_FRAME_CNT_EN
    output logic               o_frame_start,
    output logic [15:0]        o_frame_cnt
`else
    output logic               o_frame_start
`endif
);

    localparam int unsigned H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int unsigned V_BLANK = V_FP + V_SYNC + V_BP;
    localparam int unsigned H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int unsigned V_TOTAL = V_BLANK + V_ACTIVE;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] D_LAST     = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_FP + H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_BLANK);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_FP + V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_BLANK);

    logic [DW-1:0]      div_cnt;
    logic [HW-1:0]      h_cnt;
    logic [VW-1:0]      v_cnt;

    logic [DW-1:0]      div_next_c;
    logic [HW-1:0]      h_next_c;
    logic [VW-1:0]      v_next_c;
    logic               h_wrap_c;
    logic               v_wrap_c;
    logic               hs_on_c;
    logic               vs_on_c;
    logic               active_c;
    logic [COORD_W-1:0] x_c;
    logic [COORD_W-1:0] y_c;

    // Next divider and scan-counter values; counters move only on a pixel tick
    always_comb begin
        div_next_c = (div_cnt == D_LAST) ? '0 : div_cnt + DW'(1);
        h_next_c   = h_cnt;
        v_next_c   = v_cnt;
        h_wrap_c   = 1'b0;
        v_wrap_c   = 1'b0;
        if (o_pix_tick) begin
            if (h_cnt == H_LAST) begin
                h_wrap_c = 1'b1;
                h_next_c = '0;
                if (v_cnt == V_LAST) begin
                    v_wrap_c = 1'b1;
                    v_next_c = '0;
                end else begin
                    v_next_c = v_cnt + VW'(1);
                end
            end else begin
                h_next_c = h_cnt + HW'(1);
            end
        end
    end

    // Decode sync/active/coordinates from the next counter values
    always_comb begin
        hs_on_c  = (h_next_c >= H_SYNC_BEG) && (h_next_c < H_SYNC_END);
        vs_on_c  = (v_next_c >= V_SYNC_BEG) && (v_next_c < V_SYNC_END);
        active_c = (h_next_c >= H_ACT_BEG) && (v_next_c >= V_ACT_BEG);
        x_c      = '0;
        y_c      = '0;
        if (active_c) begin
            x_c = COORD_W'(h_next_c - H_ACT_BEG);
            y_c = COORD_W'(v_next_c - V_ACT_BEG);
        end
    end

    // Counter and output registers, all updated on the same edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt       <= '0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            o_pix_tick    <= 1'b0;
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_active      <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            div_cnt       <= div_next_c;
            h_cnt         <= h_next_c;
            v_cnt         <= v_next_c;
            o_pix_tick    <= (div_next_c == D_LAST);
            o_hsync       <= hs_on_c ? HS_POL : ~HS_POL;
            o_vsync       <= vs_on_c ? VS_POL : ~VS_POL;
            o_active      <= active_c;
            o_x           <= x_c;
            o_y           <= y_c;
            o_line_start  <= h_wrap_c;
            o_frame_start <= v_wrap_c;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter, visible incremented in the frame_start cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_frame_cnt <= '0;
        end else if (v_wrap_c) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default-timing instance (CLK_DIV=4,
// active-low syncs) and a small-geometry instance (CLK_DIV=1, active-high syncs).
// Expected states are queued by scan position; monitors pop them as the DUTs advance.
module tb_vga_timing_gen;

    typedef struct {
        int   idx;
        logic hs;
        logic vs;
        logic act;
        int   x;
        int   y;
        logic ls;
        logic fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic       a_tick, a_hs, a_vs, a_act, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_hs, b_vs, b_act, b_ls, b_fs;
    logic [9:0] b_x, b_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] a_fc, b_fc;
`endif

    int errors = 0;
    int checks = 0;

    exp_t qa[$];
    exp_t qb[$];

    int   n_a, ec_a, last_a;
    logic pend_a;
    int   n_b, ec_b, last_b;
    logic pend_b;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .o_pix_tick(a_tick),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_active(a_act),
        .o_x(a_x), .o_y(a_y), .o_line_start(a_ls),
`ifdef VGA_FRAME_CNT_EN
        .o_frame_start(a_fs), .o_frame_cnt(a_fc)
`else
        .o_frame_start(a_fs)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .COORD_W(10)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .o_pix_tick(b_tick),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_active(b_act),
        .o_x(b_x), .o_y(b_y), .o_line_start(b_ls),
`ifdef VGA_FRAME_CNT_EN
        .o_frame_start(b_fs), .o_frame_cnt(b_fc)
`else
        .o_frame_start(b_fs)
`endif
    );

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void push(bit which, int idx, logic hs, logic vs, logic act,
                                 int x, int y, logic ls, logic fs);
        exp_t e;
        e.idx = idx; e.hs = hs; e.vs = vs; e.act = act;
        e.x = x; e.y = y; e.ls = ls; e.fs = fs;
        if (which) qb.push_back(e);
        else       qa.push_back(e);
    endfunction

    function automatic void cmp(string tag, exp_t e, logic hs, logic vs, logic act,
                                int x, int y, logic ls, logic fs);
        chk($sformatf("%s@%0d hsync", tag, e.idx), int'(hs), int'(e.hs));
        chk($sformatf("%s@%0d vsync", tag, e.idx), int'(vs), int'(e.vs));
        chk($sformatf("%s@%0d active", tag, e.idx), int'(act), int'(e.act));
        chk($sformatf("%s@%0d x", tag, e.idx), x, e.x);
        chk($sformatf("%s@%0d y", tag, e.idx), y, e.y);
        chk($sformatf("%s@%0d line_start", tag, e.idx), int'(ls), int'(e.ls));
        chk($sformatf("%s@%0d frame_start", tag, e.idx), int'(fs), int'(e.fs));
    endfunction

    function automatic void chk_reset(string tag);
        chk({tag, " a_tick"}, int'(a_tick), 0);
        chk({tag, " a_hsync"}, int'(a_hs), 1);
        chk({tag, " a_vsync"}, int'(a_vs), 1);
        chk({tag, " a_active"}, int'(a_act), 0);
        chk({tag, " a_x"}, int'(a_x), 0);
        chk({tag, " a_y"}, int'(a_y), 0);
        chk({tag, " a_strobes"}, int'({a_ls, a_fs}), 0);
        chk({tag, " b_tick"}, int'(b_tick), 0);
        chk({tag, " b_hsync"}, int'(b_hs), 0);
        chk({tag, " b_vsync"}, int'(b_vs), 0);
        chk({tag, " b_active"}, int'(b_act), 0);
        chk({tag, " b_x"}, int'(b_x), 0);
        chk({tag, " b_y"}, int'(b_y), 0);
        chk({tag, " b_strobes"}, int'({b_ls, b_fs}), 0);
`ifdef VGA_FRAME_CNT_EN
        chk({tag, " a_frame_cnt"}, int'(a_fc), 0);
        chk({tag, " b_frame_cnt"}, int'(b_fc), 0);
`endif
    endfunction

    // Monitor A: 800-pixel lines, one advance every 4 clocks
    always @(negedge clk) begin
        if (!rst_n) begin
            n_a = 0; ec_a = 0; last_a = 0; pend_a = 1'b0;
        end else begin
            ec_a++;
            if (pend_a) begin
                n_a++;
                if (n_a == 1) chk("a_first_advance_edge", ec_a, 4);
                else          chk("a_tick_period", ec_a - last_a, 4);
                last_a = ec_a;
            end
            chk("a_line_start_pulse", int'(a_ls), int'(pend_a && (n_a % 800 == 0)));
            chk("a_frame_start_pulse", int'(a_fs), 0);
            if (pend_a && qa.size() > 0 && qa[0].idx == n_a)
                cmp("a", qa.pop_front(), a_hs, a_vs, a_act, int'(a_x), int'(a_y), a_ls, a_fs);
            pend_a = a_tick;
        end
    end

    // Monitor B: 7-pixel lines, 6-line frames, one advance per clock
    always @(negedge clk) begin
        if (!rst_n) begin
            n_b = 0; ec_b = 0; last_b = 0; pend_b = 1'b0;
        end else begin
            ec_b++;
            if (pend_b) begin
                n_b++;
                if (n_b > 1) chk("b_tick_period", ec_b - last_b, 1);
                last_b = ec_b;
            end
            chk("b_line_start_pulse", int'(b_ls), int'(pend_b && (n_b % 7 == 0)));
            chk("b_frame_start_pulse", int'(b_fs), int'(pend_b && (n_b % 42 == 0)));
`ifdef VGA_FRAME_CNT_EN
            chk("b_frame_cnt", int'(b_fc), n_b / 42);
`endif
            if (pend_b && qb.size() > 0 && qb[0].idx == n_b)
                cmp("b", qb.pop_front(), b_hs, b_vs, b_act, int'(b_x), int'(b_y), b_ls, b_fs);
            pend_b = b_tick;
        end
    end

    task automatic wait_drain(string tag);
        int i;
        i = 0;
        while ((qa.size() > 0 || qb.size() > 0) && i < 20000) begin
            @(negedge clk); #1;
            i++;
        end
        chk({tag, " a_queue_left"}, qa.size(), 0);
        chk({tag, " b_queue_left"}, qb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;

        // Default geometry: hsync low on pixels 16..111, line length 800
        push(0, 1,    1, 1, 0, 0, 0, 0, 0);
        push(0, 15,   1, 1, 0, 0, 0, 0, 0);
        push(0, 16,   0, 1, 0, 0, 0, 0, 0);
        push(0, 111,  0, 1, 0, 0, 0, 0, 0);
        push(0, 112,  1, 1, 0, 0, 0, 0, 0);
        push(0, 160,  1, 1, 0, 0, 0, 0, 0);
        push(0, 799,  1, 1, 0, 0, 0, 0, 0);
        push(0, 800,  1, 1, 0, 0, 0, 1, 0);
        push(0, 816,  0, 1, 0, 0, 0, 0, 0);
        push(0, 1600, 1, 1, 0, 0, 0, 1, 0);

        // Small geometry: sync at h/v=1, active h 3..6 / v 3..5
        push(1, 1,  1, 0, 0, 0, 0, 0, 0);
        push(1, 2,  0, 0, 0, 0, 0, 0, 0);
        push(1, 3,  0, 0, 0, 0, 0, 0, 0);
        push(1, 7,  0, 1, 0, 0, 0, 1, 0);
        push(1, 8,  1, 1, 0, 0, 0, 0, 0);
        push(1, 14, 0, 0, 0, 0, 0, 1, 0);
        push(1, 24, 0, 0, 1, 0, 0, 0, 0);
        push(1, 27, 0, 0, 1, 3, 0, 0, 0);
        push(1, 31, 0, 0, 1, 0, 1, 0, 0);
        push(1, 41, 0, 0, 1, 3, 2, 0, 0);
        push(1, 42, 0, 0, 0, 0, 0, 1, 1);
        push(1, 43, 1, 0, 0, 0, 0, 0, 0);
        push(1, 84, 0, 0, 0, 0, 0, 1, 1);

        repeat (2) @(negedge clk);
        #1 chk_reset("power_on");
        rst_n = 1'b1;
        wait_drain("run1");

        // Reset in the middle of a line (default instance at h=300)
        begin
            int i;
            i = 0;
            while (n_a != 1900 && i < 20000) begin
                @(negedge clk); #1;
                i++;
            end
            chk("reach_h300", n_a, 1900);
        end
        rst_n = 1'b0;
        #1 chk_reset("mid_line");

        push(0, 1,   1, 1, 0, 0, 0, 0, 0);
        push(0, 16,  0, 1, 0, 0, 0, 0, 0);
        push(0, 112, 1, 1, 0, 0, 0, 0, 0);
        push(1, 7,   0, 1, 0, 0, 0, 1, 0);
        push(1, 42,  0, 0, 0, 0, 0, 1, 1);

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_drain("run2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
